// File: rtl/adc_spi_pkg.sv
// rtl/adc_spi_pkg.sv - shared FSM state type and default parameters for the ADC SPI sampler
package adc_spi_pkg;

  // SCLK half-period in clk cycles
  localparam int CLK_DIV_DEF    = 4;
  // clk cycles per sample period (100 MHz / 4536 = ~22.05 kHz)
  localparam int SAMPLE_DIV_DEF = 4536;
  // SCLK rising edges per conversion frame
  localparam int NBITS_DEF      = 16;
  // result bits kept, taken from the LSBs of the frame
  localparam int DATA_W_DEF     = 12;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } adc_state_t;

endpackage

// File: rtl/sample_rate_tick.sv
// rtl/sample_rate_tick.sv - free-running sample-period divider producing a one-cycle tick
module sample_rate_tick
  import adc_spi_pkg::*;
#(
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = $clog2(SAMPLE_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             wrap;

  // Count 0..SAMPLE_DIV-1 while enabled; park at zero when disabled
  always_comb begin
    wrap   = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
    cnt_d  = (!enable || wrap) ? '0 : cnt_q + 1'b1;
    tick_d = enable && wrap;
  end

  // Counter and registered tick; the tick lands on the cycle the count restarts at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  // Gated so a wrap on the same cycle enable falls cannot start a new frame
  assign tick = tick_q && enable;

endmodule

// File: rtl/adc_spi_sampler.sv
// rtl/adc_spi_sampler.sv - periodic SPI ADC reader with chip-select framing and overrun detect
module adc_spi_sampler
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEF,
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
  parameter int NBITS      = NBITS_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              miso,
  output logic              cs_n,
  output logic              sclk,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int BIT_W = ($clog2(NBITS + 1) > 5) ? $clog2(NBITS + 1) : 5;

  logic              tick;
  logic              div_last;
  adc_state_t        state_q, state_d;
  logic [7:0]        div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  // Only the low DATA_W bits of a frame survive, so older bits simply fall off the top
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              sample_valid_q, sample_valid_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;

  sample_rate_tick #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .tick  (tick)
  );

  // Frame sequencing, bit capture and decode of the pins for the next state
  always_comb begin
    state_d        = state_q;
    div_d          = div_q;
    bit_d          = bit_q;
    shift_d        = shift_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    div_last       = (div_q == 8'(CLK_DIV - 1));

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SETUP;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      SETUP: begin
        if (div_last) begin
          state_d = SHIFT_LO;
          div_d   = '0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      SHIFT_LO: begin
        if (div_last) begin
          state_d = SHIFT_HI;
          div_d   = '0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      SHIFT_HI: begin
        // First high cycle is the one where sclk has just risen
        if (div_q == 8'd0) begin
          shift_d = {shift_q[DATA_W-2:0], miso};
        end
        if (div_last) begin
          div_d = '0;
          bit_d = bit_q + 1'b1;
          if (bit_q == BIT_W'(NBITS - 1)) begin
            // Load the result on the way into DONE so it is visible with the pulse
            state_d        = DONE;
            sample_d       = shift_q;
            sample_valid_d = 1'b1;
          end else begin
            state_d = SHIFT_LO;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cs_n_d    = !(state_d == SETUP || state_d == SHIFT_LO || state_d == SHIFT_HI);
    sclk_d    = (state_d != SHIFT_LO);
    busy_d    = (state_d != IDLE);
    // A tick that finds the FSM anywhere but IDLE (DONE included) is lost
    overrun_d = enable && (overrun_q || (tick && state_q != IDLE));
  end

  // FSM state plus registered pins; reset abandons any frame in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      div_q          <= '0;
      bit_q          <= '0;
      shift_q        <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      cs_n_q         <= 1'b1;
      sclk_q         <= 1'b1;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      div_q          <= div_d;
      bit_q          <= bit_d;
      shift_q        <= shift_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      cs_n_q         <= cs_n_d;
      sclk_q         <= sclk_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
    end
  end

  assign cs_n         = cs_n_q;
  assign sclk         = sclk_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule

// File: doc/adc_spi_sampler.md
ADC_SPI_SAMPLER -- requirements
Module: adc_spi_sampler

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4; SCLK half-period in clk cycles, legal 2..255.
REQ-002 SHALL have parameter SAMPLE_DIV, default 4536; clk cycles per sample period (100 MHz / 4536 = 22045 Hz), legal > 34*CLK_DIV.
REQ-003 SHALL have parameter NBITS, default 16; SCLK edges per frame.
REQ-004 SHALL have parameter DATA_W, default 12; valid result bits, the LSBs of the frame.
REQ-005 clk  input  1  system clock, all logic on posedge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  high = periodic sampling runs.
REQ-008 miso  input  1  serial data from ADC.
REQ-009 cs_n  output  1  ADC chip select, active-low.
REQ-010 sclk  output  1  serial clock, idle high.
REQ-011 sample  output  DATA_W  last completed conversion.
REQ-012 sample_valid  output  1  one-cycle pulse when sample updates.
REQ-013 busy  output  1  high whenever state != IDLE.
REQ-014 overrun  output  1  sticky flag: sample tick arrived while busy.

Function
REQ-015 Tick counter SHALL count 0..SAMPLE_DIV-1 while enable=1, wrap to 0, and raise an internal one-cycle tick on the wrap cycle; held at 0 while enable=0.
REQ-016 FSM states SHALL be IDLE, SETUP, SHIFT_LO, SHIFT_HI, DONE.
REQ-017 IDLE: cs_n=1, sclk=1; on tick go to SETUP next cycle.
REQ-018 SETUP: cs_n=0, sclk=1 for exactly CLK_DIV cycles, then SHIFT_LO.
REQ-019 SHIFT_LO: sclk=0 for CLK_DIV cycles, then SHIFT_HI; SHIFT_HI: sclk=1 for CLK_DIV cycles.
REQ-020 miso SHALL be shifted in MSB-first on the clk cycle sclk goes 0->1 (first cycle of SHIFT_HI).
REQ-021 After the NBITS-th SHIFT_HI completes, FSM SHALL go to DONE; otherwise back to SHIFT_LO.
REQ-022 DONE: cs_n=1, sclk=1, sample <= shift[DATA_W-1:0], sample_valid=1 for exactly that one cycle, then IDLE.
REQ-023 Latency: tick at cycle T -> sample_valid at cycle T+1+CLK_DIV*(1+2*NBITS) (T+133 with defaults).
REQ-024 Bit counter SHALL be 5 bits minimum, cleared on entry to SETUP.
REQ-025 Tick while busy=1 SHALL be dropped and SHALL set overrun; overrun clears only on reset or enable=0.
REQ-026 enable falling mid-frame SHALL NOT abort the frame; the frame completes and delivers sample_valid; no new tick follows.
REQ-027 Tick coinciding with DONE SHALL count as overrun (DONE is busy).
REQ-028 cs_n and sclk SHALL be registered outputs, glitch-free.

Reset
REQ-029 On reset: state=IDLE, cs_n=1, sclk=1, sample=0, sample_valid=0, busy=0, overrun=0, tick counter=0, shift register=0, immediately (asynchronous).
REQ-030 Reset mid-frame SHALL abandon the frame with no sample_valid; sampling restarts a full SAMPLE_DIV period after reset release if enable=1.

Structure
REQ-031 Package adc_spi_pkg SHALL hold the FSM state typedef and default constants (CLK_DIV, SAMPLE_DIV, NBITS, DATA_W).
REQ-032 Tick counter SHALL be a sub-module sample_rate_tick (clk, reset, enable -> tick), parameterised by SAMPLE_DIV.

Verification
REQ-033 Reset, enable=1, ADC model returns 0x0ABC in 16 bits -> first sample_valid at cycle SAMPLE_DIV+133 after release, sample=0xABC.
REQ-034 Continuous run 5 periods -> sample_valid pulses exactly 4536 cycles apart, cs_n low for exactly 132 cycles per frame, 16 sclk rising edges each.
REQ-035 SAMPLE_DIV=100, CLK_DIV=4 (frame 133 > 100) -> overrun=1 after second tick, every other frame dropped, data still correct.
REQ-036 enable dropped 10 cycles into SHIFT -> frame completes, sample_valid once, then cs_n stays high, overrun cleared.
REQ-037 reset asserted during SHIFT_LO -> same cycle cs_n=1, sclk=1, no sample_valid, sample=0.
REQ-038 ADC model bits 0xF000 | 0x555 -> sample=0x555 (upper 4 bits discarded).
